// File: rtl/switch_rx_pkg.sv
// Shared types and packet-layout constants for the per-port switch receiver.
package switch_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_SEND
    } rx_state_t;

    localparam int HDR_BYTES = 3;
    localparam int MIN_PKT   = 4;
    localparam int OFF_DA    = 0;
    localparam int OFF_SA    = 1;
    localparam int OFF_LEN   = 2;

endpackage

// File: rtl/rx_pkt_buffer.sv
// Single-clock simple dual-port packet store: one write port, one registered read port.
module rx_pkt_buffer #(
    parameter int DEPTH = 68,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the output byte, so it must reset to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/switch_port_rx.sv
// Per-port receiver: drains one packet from a switch port, validates length/FCS, forwards good packets.
module switch_port_rx
    import switch_rx_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready_in,
    output logic             read_out,
    input  logic [7:0]       port_data,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sop,
    output logic             m_eop,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    output logic [CNT_W-1:0] fcs_err_cnt
);

    localparam int DEPTH = MAX_LEN + 4;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rx_state_t       state;
    logic            rd_d;
    logic [8:0]      count;
    logic [8:0]      send_idx;
    logic            overflow;
    logic [7:0]      len_byte;
    logic [7:0]      xor_acc;
    logic            capture;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            len_err;
    logic            fcs_err;
    logic            last_byte;

    // A byte is on port_data exactly when read_out was high the cycle before.
    always_comb begin
        capture   = (state == ST_RECV) && rd_d;
        wr_en     = capture && (count < 9'(DEPTH));
        wr_addr   = count[AW-1:0];
        len_err   = overflow
                 || ({1'b0, len_byte} > 9'(MAX_LEN))
                 || (count != ({1'b0, len_byte} + 9'(HDR_BYTES + 1)))
                 || (count < 9'(MIN_PKT));
        fcs_err   = (xor_acc != 8'h00);
        last_byte = (send_idx == (count - 9'd1));
        rd_en     = 1'b0;
        rd_addr   = send_idx[AW-1:0];
        if (state == ST_CHECK && !len_err && !fcs_err) begin
            rd_en   = 1'b1;
            rd_addr = AW'(OFF_DA);
        end else if (state == ST_SEND && m_valid && m_ready && !last_byte) begin
            rd_en   = 1'b1;
            rd_addr = AW'(send_idx + 9'd1);
        end
    end

    rx_pkt_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (port_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (m_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            read_out    <= 1'b0;
            rd_d        <= 1'b0;
            count       <= '0;
            send_idx    <= '0;
            overflow    <= 1'b0;
            len_byte    <= 8'h00;
            xor_acc     <= 8'h00;
            m_valid     <= 1'b0;
            m_sop       <= 1'b0;
            m_eop       <= 1'b0;
            good_cnt    <= '0;
            len_err_cnt <= '0;
            fcs_err_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    read_out <= 1'b0;
                    m_valid  <= 1'b0;
                    if (ready_in) begin
                        state    <= ST_RECV;
                        read_out <= 1'b1;
                        rd_d     <= 1'b0;
                        count    <= '0;
                        overflow <= 1'b0;
                        len_byte <= 8'h00;
                        xor_acc  <= 8'h00;
                    end
                end
                ST_RECV: begin
                    // Once read drops it stays low, so a one-cycle ready glitch truncates the packet.
                    read_out <= ready_in && read_out;
                    rd_d     <= read_out;
                    if (capture) begin
                        xor_acc <= xor_acc ^ port_data;
                        if (count < 9'(DEPTH)) begin
                            count <= count + 9'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (count == 9'(OFF_LEN)) begin
                            len_byte <= port_data;
                        end
                    end
                    if (!rd_d && !read_out) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (len_err) begin
                        if (len_err_cnt != '1) len_err_cnt <= len_err_cnt + 1'b1;
                        state <= ST_IDLE;
                    end else if (fcs_err) begin
                        if (fcs_err_cnt != '1) fcs_err_cnt <= fcs_err_cnt + 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_SEND;
                        send_idx <= '0;
                        m_valid  <= 1'b1;
                        m_sop    <= 1'b1;
                        m_eop    <= (count == 9'd1);
                    end
                end
                ST_SEND: begin
                    read_out <= 1'b0;
                    if (m_valid && m_ready) begin
                        m_sop <= 1'b0;
                        if (last_byte) begin
                            m_valid <= 1'b0;
                            m_eop   <= 1'b0;
                            if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            send_idx <= send_idx + 9'd1;
                            m_eop    <= ((send_idx + 9'd2) == count);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_port_rx.sv
// Self-checking bench for switch_port_rx: switch-side byte source, table of packets, output scoreboard.
module tb_switch_port_rx;

    localparam int MAX_LEN = 64;
    localparam int CNT_W   = 16;
    localparam int KIND_GOOD = 0;
    localparam int KIND_LEN  = 1;
    localparam int KIND_FCS  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ready_in = 1'b0;
    logic             read_out;
    logic [7:0]       port_data = 8'h00;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic             m_sop;
    logic             m_eop;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] len_err_cnt;
    logic [CNT_W-1:0] fcs_err_cnt;

    typedef struct {
        logic [7:0] da;
        logic [7:0] sa;
        logic [7:0] len_field;
        logic [7:0] pay_base;
        int         n_deliver;
        bit         fcs_flip;
        int         kind;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    vec_t       vecs [9];
    beat_t      exp_q [$];
    logic [7:0] sw_q [$];
    logic [7:0] pkt [$];
    int         unrequested = 0;
    int         served = 0;
    int         out_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_good = 0;
    int         exp_len = 0;
    int         exp_fcs = 0;

    always #5 clk = ~clk;

    switch_port_rx #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ready_in    (ready_in),
        .read_out    (read_out),
        .port_data   (port_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sop       (m_sop),
        .m_eop       (m_eop),
        .good_cnt    (good_cnt),
        .len_err_cnt (len_err_cnt),
        .fcs_err_cnt (fcs_err_cnt)
    );

    // Switch model: ready stays high until every queued byte has been requested.
    always @(posedge clk) begin : switch_model
        logic was_read;
        was_read = read_out;
        #1;
        if (!reset) begin
            sw_q.delete();
            unrequested = 0;
        end else begin
            if (was_read && sw_q.size() > 0) begin
                port_data = sw_q.pop_front();
                served++;
            end
            if (read_out && unrequested > 0) unrequested--;
        end
        ready_in = (unrequested > 0);
    end

    always @(negedge clk) begin : out_monitor
        beat_t e;
        if (reset && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_beat got data=%02h sop=%0b eop=%0b, none required", m_data, m_sop, m_eop);
            end else begin
                e = exp_q.pop_front();
                if ({m_data, m_sop, m_eop} !== e) begin
                    errors++;
                    $display("[TB] FAIL beat_%0d got data=%02h sop=%0b eop=%0b, required data=%02h sop=%0b eop=%0b",
                             out_cnt, m_data, m_sop, m_eop, e.data, e.sop, e.eop);
                end
            end
            out_cnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic buildPkt(input vec_t v);
        logic [7:0] fcs;
        logic [7:0] p;
        pkt.delete();
        fcs = v.da ^ v.sa ^ v.len_field;
        pkt.push_back(v.da);
        pkt.push_back(v.sa);
        pkt.push_back(v.len_field);
        for (int i = 0; i < int'(v.len_field); i++) begin
            p = v.pay_base + 8'(i);
            pkt.push_back(p);
            fcs = fcs ^ p;
        end
        pkt.push_back(fcs ^ {7'b0, v.fcs_flip});
        while (pkt.size() > v.n_deliver) void'(pkt.pop_back());
        while (pkt.size() < v.n_deliver) pkt.push_back(8'h5A);
    endtask

    task automatic applyStimulus(input vec_t v);
        beat_t b;
        buildPkt(v);
        @(posedge clk);
        #2;
        if (v.kind == KIND_GOOD) begin
            for (int i = 0; i < pkt.size(); i++) begin
                b.data = pkt[i];
                b.sop  = (i == 0);
                b.eop  = (i == pkt.size() - 1);
                exp_q.push_back(b);
            end
            exp_good++;
        end else if (v.kind == KIND_LEN) begin
            exp_len++;
        end else begin
            exp_fcs++;
        end
        foreach (pkt[i]) sw_q.push_back(pkt[i]);
        unrequested += pkt.size();
    endtask

    task automatic waitDone(input string name);
        int cyc;
        cyc = 0;
        while ((sw_q.size() > 0 || unrequested > 0 || exp_q.size() > 0 || read_out || m_valid) && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput({name, "_done_in_time"}, 32'(cyc < 2000), 1);
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic checkCounters(input string name);
        checkOutput({name, "_good_cnt"}, 32'(good_cnt), exp_good);
        checkOutput({name, "_len_err_cnt"}, 32'(len_err_cnt), exp_len);
        checkOutput({name, "_fcs_err_cnt"}, 32'(fcs_err_cnt), exp_fcs);
        checkOutput({name, "_read_out_idle"}, 32'(read_out), 0);
        checkOutput({name, "_m_valid_idle"}, 32'(m_valid), 0);
    endtask

    initial begin
        vec_t va;
        vec_t vb;
        int   base;
        int   cyc;
        int   s0;

        vecs[0] = '{8'h11, 8'h22, 8'h03, 8'hA0, 7,  1'b0, KIND_GOOD};
        vecs[1] = '{8'h11, 8'h22, 8'h03, 8'hA0, 7,  1'b1, KIND_FCS};
        vecs[2] = '{8'h33, 8'h44, 8'h50, 8'h00, 84, 1'b0, KIND_LEN};
        vecs[3] = '{8'h55, 8'h66, 8'h05, 8'h10, 6,  1'b0, KIND_LEN};
        vecs[4] = '{8'h77, 8'h88, 8'h00, 8'h00, 4,  1'b0, KIND_GOOD};
        vecs[5] = '{8'h99, 8'hAA, 8'h40, 8'h20, 68, 1'b0, KIND_GOOD};
        vecs[6] = '{8'hBB, 8'hCC, 8'h41, 8'h30, 69, 1'b0, KIND_LEN};
        vecs[7] = '{8'hDD, 8'hEE, 8'h02, 8'h40, 7,  1'b0, KIND_LEN};
        vecs[8] = '{8'h01, 8'h02, 8'h00, 8'h00, 3,  1'b0, KIND_LEN};

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_read_out", 32'(read_out), 0);
        checkOutput("rst_m_valid", 32'(m_valid), 0);
        checkOutput("rst_m_sop", 32'(m_sop), 0);
        checkOutput("rst_m_eop", 32'(m_eop), 0);
        checkOutput("rst_m_data", 32'(m_data), 0);
        checkOutput("rst_good_cnt", 32'(good_cnt), 0);
        checkOutput("rst_err_cnts", 32'({len_err_cnt, fcs_err_cnt}), 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            waitDone($sformatf("vec%0d", i));
            checkCounters($sformatf("vec%0d", i));
        end

        // Stall byte 2 of packet A for three cycles while packet B is already pending at the switch.
        va = '{8'h31, 8'h42, 8'h04, 8'h10, 8, 1'b0, KIND_GOOD};
        vb = '{8'h51, 8'h62, 8'h01, 8'h70, 5, 1'b0, KIND_GOOD};
        base = out_cnt;
        applyStimulus(va);
        cyc = 0;
        while (!m_valid && cyc < 300) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        checkOutput("stall_first_valid", 32'(m_valid), 1);
        applyStimulus(vb);
        cyc = 0;
        while (!(m_valid && out_cnt == base + 2) && cyc < 50) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        checkOutput("stall_reach_byte2", 32'(out_cnt - base), 2);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_data_held", 32'(m_data), 32'(va.len_field));
            checkOutput("stall_valid_held", 32'({m_valid, m_sop, m_eop}), 32'b100);
            checkOutput("stall_read_out", 32'(read_out), 0);
        end
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        waitDone("stall");
        checkCounters("stall");

        // Reset in the middle of receiving byte 4 of a packet.
        buildPkt('{8'h12, 8'h34, 8'h0A, 8'h80, 14, 1'b0, KIND_GOOD});
        @(posedge clk);
        #2;
        s0 = served;
        foreach (pkt[i]) sw_q.push_back(pkt[i]);
        unrequested += pkt.size();
        cyc = 0;
        while (served < s0 + 4 && cyc < 100) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        checkOutput("midrst_reached_byte4", 32'(served - s0), 4);
        reset = 1'b0;
        exp_good = 0;
        exp_len  = 0;
        exp_fcs  = 0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("midrst_outputs", 32'({read_out, m_valid, m_sop, m_eop, m_data}), 0);
        checkCounters("midrst");
        reset = 1'b1;
        applyStimulus(vecs[0]);
        waitDone("postrst");
        checkCounters("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
